// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access size, FSM state and the
// alignment check used at request acceptance.
package lsu_pkg;

   typedef enum logic [1:0] {
      SIZE_B = 2'b00,
      SIZE_H = 2'b01,
      SIZE_W = 2'b10
   } size_e;

   typedef enum logic {
      IDLE  = 1'b0,
      MERGE = 1'b1
   } state_e;

   // Size 2'b11 has no enum member and is always rejected.
   function automatic logic access_bad(input logic [1:0] size, input logic [1:0] lo);
      logic bad;
      bad = 1'b0;
      case (size)
         SIZE_B:  bad = 1'b0;
         SIZE_H:  bad = lo[0];
         SIZE_W:  bad = (lo != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lsu_lane.sv
// Combinational byte/half lane logic: with DO_MERGE=0 it extracts and extends
// the addressed lane of a word; with DO_MERGE=1 it overlays wdata onto that lane.
module lsu_lane
   import lsu_pkg::*;
#(
   parameter bit DO_MERGE = 1'b0
) (
   input  logic [31:0] word,
   input  logic [1:0]  lo,
   input  logic [1:0]  size,
   input  logic        uns,
   input  logic [31:0] wdata,
   output logic [31:0] result
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   always_comb begin
      lane_b = word[{lo, 3'b000} +: 8];
      lane_h = word[{lo[1], 4'b0000} +: 16];
      result = word;
      if (DO_MERGE) begin
         case (size)
            SIZE_B:  result[{lo, 3'b000} +: 8]     = wdata[7:0];
            SIZE_H:  result[{lo[1], 4'b0000} +: 16] = wdata[15:0];
            default: result = wdata;
         endcase
      end else begin
         case (size)
            SIZE_B:  result = {{24{~uns & lane_b[7]}}, lane_b};
            SIZE_H:  result = {{16{~uns & lane_h[15]}}, lane_h};
            default: result = word;
         endcase
      end
   end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit over a word-wide asynchronous-read data memory.
// Sub-word stores take a read-modify-write pass through the MERGE state.
module load_store_unit
   import lsu_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_we,
   output logic [31:0] mem_a,
   output logic [31:0] mem_wd,
   input  logic [31:0] mem_rd
);

   state_e      state;
   logic [29:0] cap_waddr;
   logic [1:0]  cap_lo;
   logic [1:0]  cap_size;
   logic [31:0] cap_word;
   logic [31:0] cap_wdata;

   logic        accept, bad, word_store;
   logic [31:0] ld_data, mrg_data;

   // Gating with reset_n keeps mem_we low while reset is held, whatever the request.
   assign req_ready  = (state == IDLE);
   assign accept     = req_valid & req_ready & reset_n;
   assign bad        = access_bad(req_size, req_addr[1:0]);
   assign word_store = accept & req_we & ~bad & (req_size == SIZE_W);

   assign mem_we = (state == MERGE) | word_store;
   assign mem_a  = (state == MERGE) ? {cap_waddr, 2'b00} : {req_addr[31:2], 2'b00};
   assign mem_wd = (state == MERGE) ? mrg_data : req_wdata;

   lsu_lane #(.DO_MERGE(1'b0)) u_extract (
      .word   (mem_rd),
      .lo     (req_addr[1:0]),
      .size   (req_size),
      .uns    (req_unsigned),
      .wdata  (32'h0),
      .result (ld_data)
   );

   lsu_lane #(.DO_MERGE(1'b1)) u_merge (
      .word   (cap_word),
      .lo     (cap_lo),
      .size   (cap_size),
      .uns    (1'b0),
      .wdata  (cap_wdata),
      .result (mrg_data)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= '0;
         cap_waddr  <= '0;
         cap_lo     <= '0;
         cap_size   <= '0;
         cap_word   <= '0;
         cap_wdata  <= '0;
      end else begin
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= '0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (bad) begin
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                  end else if (!req_we) begin
                     resp_valid <= 1'b1;
                     resp_rdata <= ld_data;
                  end else if (req_size == SIZE_W) begin
                     resp_valid <= 1'b1;
                  end else begin
                     // Old word is read this cycle and rewritten from MERGE.
                     state     <= MERGE;
                     cap_waddr <= req_addr[31:2];
                     cap_lo    <= req_addr[1:0];
                     cap_size  <= req_size;
                     cap_word  <= mem_rd;
                     cap_wdata <= req_wdata;
                  end
               end
            end
            MERGE: begin
               state      <= IDLE;
               resp_valid <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a vector table of single transactions
// plus hand-written sequences for merge, back-to-back and reset-in-merge.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid, req_we, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        req_ready, resp_valid, resp_err, mem_we;
   logic [31:0] resp_rdata, mem_a, mem_wd, mem_rd;

   logic [31:0] mem [64];
   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   assign mem_rd = mem[mem_a[7:2]];
   always @(posedge clk) if (mem_we) mem[mem_a[7:2]] <= mem_wd;

   load_store_unit dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .req_valid    (req_valid),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .req_ready    (req_ready),
      .resp_valid   (resp_valid),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err),
      .mem_we       (mem_we),
      .mem_a        (mem_a),
      .mem_wd       (mem_wd),
      .mem_rd       (mem_rd)
   );

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        exp_we;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t tbl [14];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
      req_valid    = 1'b1;
      req_we       = we;
      req_size     = size;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wdata;
   endtask

   initial begin
      //            we    size   uns   addr    wdata         we    rdata         err
      tbl[0]  = '{1'b0, 2'b00, 1'b0, 32'h11, 32'h0,        1'b0, 32'hFFFFFFAA, 1'b0};
      tbl[1]  = '{1'b0, 2'b01, 1'b1, 32'h12, 32'h0,        1'b0, 32'h00008899, 1'b0};
      tbl[2]  = '{1'b0, 2'b01, 1'b0, 32'h11, 32'h0,        1'b0, 32'h0,        1'b1};
      tbl[3]  = '{1'b0, 2'b00, 1'b1, 32'h10, 32'h0,        1'b0, 32'h000000BB, 1'b0};
      tbl[4]  = '{1'b0, 2'b01, 1'b0, 32'h10, 32'h0,        1'b0, 32'hFFFFAABB, 1'b0};
      tbl[5]  = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        1'b0, 32'h8899AABB, 1'b0};
      tbl[6]  = '{1'b0, 2'b10, 1'b0, 32'h12, 32'h0,        1'b0, 32'h0,        1'b1};
      tbl[7]  = '{1'b0, 2'b11, 1'b0, 32'h10, 32'h0,        1'b0, 32'h0,        1'b1};
      tbl[8]  = '{1'b1, 2'b10, 1'b0, 32'h00, 32'h1,        1'b1, 32'h0,        1'b0};
      tbl[9]  = '{1'b0, 2'b10, 1'b0, 32'h00, 32'h0,        1'b0, 32'h00000001, 1'b0};
      tbl[10] = '{1'b1, 2'b10, 1'b0, 32'h21, 32'hDEAD,     1'b0, 32'h0,        1'b1};
      tbl[11] = '{1'b0, 2'b00, 1'b1, 32'h13, 32'h0,        1'b0, 32'h00000088, 1'b0};
      tbl[12] = '{1'b1, 2'b11, 1'b0, 32'h20, 32'hCAFEF00D, 1'b0, 32'h0,        1'b1};
      tbl[13] = '{1'b1, 2'b01, 1'b0, 32'h23, 32'h7777,     1'b0, 32'h0,        1'b1};

      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[4] <= 32'h8899AABB;
      mem[8] <= 32'h11223344;

      reset_n = 1'b0;
      req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = 32'h0; req_wdata = 32'h0;

      repeat (2) @(posedge clk);
      #1;
      chk1("rst resp_valid", resp_valid, 1'b0);
      chk1("rst resp_err",   resp_err,   1'b0);
      chk ("rst resp_rdata", resp_rdata, 32'h0);
      chk1("rst mem_we",     mem_we,     1'b0);
      chk1("rst req_ready",  req_ready,  1'b1);
      reset_n = 1'b1;

      // Table: one transaction per vector, response checked one cycle later.
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         drive(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata);
         #1;
         chk1($sformatf("v%0d req_ready", i), req_ready, 1'b1);
         chk1($sformatf("v%0d mem_we", i),    mem_we,    tbl[i].exp_we);
         chk ($sformatf("v%0d mem_a", i),     mem_a,     tbl[i].addr & 32'hFFFFFFFC);
         @(posedge clk);
         #1;
         req_valid = 1'b0;
         chk1($sformatf("v%0d resp_valid", i), resp_valid, 1'b1);
         chk1($sformatf("v%0d resp_err", i),   resp_err,   tbl[i].exp_err);
         chk ($sformatf("v%0d resp_rdata", i), resp_rdata, tbl[i].exp_rdata);
      end
      chk("mem[0x20] untouched by bad stores", mem[8], 32'h11223344);

      // SB 0x5A to 0x13, with a load held upstream during MERGE.
      @(negedge clk);
      drive(1'b1, 2'b00, 1'b0, 32'h13, 32'h0000005A);
      #1;
      chk1("sb accept ready", req_ready, 1'b1);
      chk1("sb accept mem_we", mem_we, 1'b0);
      @(posedge clk);
      #1;
      drive(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
      chk1("sb merge ready", req_ready, 1'b0);
      chk1("sb merge resp_valid", resp_valid, 1'b0);
      chk1("sb merge mem_we", mem_we, 1'b1);
      chk ("sb merge mem_a", mem_a, 32'h10);
      chk ("sb merge mem_wd", mem_wd, 32'h5A99AABB);
      @(posedge clk);
      #1;
      chk1("sb resp_valid", resp_valid, 1'b1);
      chk1("sb resp_err", resp_err, 1'b0);
      chk ("sb resp_rdata", resp_rdata, 32'h0);
      chk1("sb ready after", req_ready, 1'b1);
      chk ("sb mem word", mem[4], 32'h5A99AABB);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      chk1("held lw resp_valid", resp_valid, 1'b1);
      chk ("held lw rdata", resp_rdata, 32'h5A99AABB);

      // Back-to-back SW then LW to 0x0.
      @(negedge clk);
      mem[0] <= 32'h0;
      drive(1'b1, 2'b10, 1'b0, 32'h0, 32'h1);
      #1;
      chk1("b2b sw mem_we", mem_we, 1'b1);
      chk ("b2b sw mem_wd", mem_wd, 32'h1);
      @(posedge clk);
      #1;
      drive(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
      chk1("b2b sw resp_valid", resp_valid, 1'b1);
      chk1("b2b lw ready", req_ready, 1'b1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      chk1("b2b lw resp_valid", resp_valid, 1'b1);
      chk ("b2b lw rdata", resp_rdata, 32'h1);
      @(posedge clk);
      #1;
      chk1("b2b idle resp_valid", resp_valid, 1'b0);

      // SH to 0x20 with reset asserted during MERGE.
      @(negedge clk);
      drive(1'b1, 2'b01, 1'b0, 32'h20, 32'h0000BEEF);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      chk1("sh in merge", req_ready, 1'b0);
      reset_n = 1'b0;
      #1;
      chk1("rim resp_valid", resp_valid, 1'b0);
      chk1("rim resp_err", resp_err, 1'b0);
      chk ("rim resp_rdata", resp_rdata, 32'h0);
      chk1("rim mem_we", mem_we, 1'b0);
      chk1("rim ready", req_ready, 1'b1);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      chk1("rim no resp after", resp_valid, 1'b0);
      @(posedge clk);
      #1;
      chk1("rim no resp later", resp_valid, 1'b0);
      chk ("rim word unchanged", mem[8], 32'h11223344);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have no parameters; data and address widths are fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  memory-stage request present this cycle.
REQ-005 req_we  input  1  1 = store, 0 = load.
REQ-006 req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-007 req_unsigned  input  1  zero-extend a sub-word load when 1; sign-extend when 0.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-justified.
REQ-010 req_ready  output  1  request accepted this cycle when high with req_valid.
REQ-011 resp_valid  output  1  one-cycle pulse on completion.
REQ-012 resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 resp_err  output  1  qualifies resp_valid; misaligned or illegal size.
REQ-014 mem_we  output  1  word write enable to data memory.
REQ-015 mem_a  output  32  word-aligned address to data memory, bits [1:0] = 0.
REQ-016 mem_wd  output  32  word write data.
REQ-017 mem_rd  input  32  asynchronous word read data from data memory.

Function
REQ-018 SHALL implement FSM states IDLE and MERGE; req_ready = (state == IDLE).
REQ-019 Error check: an access is misaligned if size=01 and addr[0]=1, or size=10 and addr[1:0]!=0; size=11 is illegal.
REQ-020 Error request accepted in IDLE: no memory write; next cycle resp_valid=1, resp_err=1, resp_rdata=0; state stays IDLE.
REQ-021 Load accepted in IDLE: mem_a={addr[31:2],2'b00} combinationally; extracted, extended lane of mem_rd registered; resp_valid next cycle (latency 1).
REQ-022 Load lane selection: byte lane addr[1:0], half lane addr[1]; word returned unchanged.
REQ-023 Word store accepted in IDLE: mem_we=1 and mem_wd=req_wdata in the same cycle; resp_valid next cycle; state stays IDLE.
REQ-024 Byte/half store accepted in IDLE: mem_we=0; mem_rd captured along with addr, size and wdata; transition to MERGE.
REQ-025 In MERGE: mem_we=1, mem_a=held word address, mem_wd=captured word with only the addressed lane(s) replaced by wdata[7:0]/[15:0]; next state IDLE; resp_valid the following cycle.
REQ-026 Requests presented in MERGE SHALL be ignored (req_ready=0); the upstream holds them.
REQ-027 Back-to-back loads/word stores SHALL be accepted every cycle with one resp_valid per request.
REQ-028 mem_we SHALL never be high in IDLE except for an aligned word store with req_valid=1.

Reset
REQ-029 reset_n low SHALL force immediately: state=IDLE, resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, and clear all capture registers.
REQ-030 Reset during MERGE SHALL abort the write, with no resp_valid after release.
REQ-031 First request is accepted on the first rising edge after reset_n deasserts.

Structure
REQ-032 Package lsu_pkg SHALL hold the size encoding enum (SIZE_B, SIZE_H, SIZE_W) and the state enum (IDLE, MERGE).
REQ-033 Lane extract/merge logic SHALL be a combinational sub-module, lsu_lane, instanced once for extract and once for merge.
REQ-034 FSM, capture registers and response registers SHALL reside in load_store_unit.

Verification
REQ-035 Memory word at 0x10 = 0x8899AABB; LB from 0x11 with unsigned=0 -> resp_rdata=0xFFFFFFAA one cycle later, resp_err=0.
REQ-036 Same word; LHU from 0x12 -> 0x00008899; LH from 0x11 -> resp_err=1, rdata=0, no mem_we.
REQ-037 SB of 0x5A to 0x13 over 0x8899AABB -> req_ready low for one cycle, MERGE writes 0x5A99AABB, resp_valid next cycle.
REQ-038 Back-to-back SW of 0x1 to 0x0, LW from 0x0 -> mem_we in cycle 0; LW returns 0x00000001; two resp_valid pulses on consecutive cycles.
REQ-039 SH to 0x20 with reset_n pulsed low during MERGE -> word at 0x20 unchanged, no resp_valid, all outputs 0 during reset.
REQ-040 req_size=11 with a load -> resp_err=1, resp_rdata=0, state IDLE.
